// File: rtl/nibble_cmp_seq.sv
// nibble_cmp_seq: compares two WIDTH-bit operands by stepping one 4-bit
// comparator slice from the most-significant nibble down, one nibble per
// cycle. It stops at the first nibble that differs. Valid/ready handshakes
// are used on both the operand side and the result side.
module nibble_cmp_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             signed_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  // One-hot cascade encoding {lt, eq, gt}, shared with the comparator slices.
  localparam logic [2:0] CASC_LT = 3'b100;
  localparam logic [2:0] CASC_EQ = 3'b010;
  localparam logic [2:0] CASC_GT = 3'b001;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("nibble_cmp_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // A 4-bit magnitude slice with a cascade input. A decided cascade passes
  // through unchanged, so the more-significant decision always wins.
  function automatic logic [2:0] cmp_slice(input logic [3:0] a_nib,
                                           input logic [3:0] b_nib,
                                           input logic [2:0] casc_in);
    logic [2:0] res;
    if (casc_in != CASC_EQ) begin
      res = casc_in;
    end else if (a_nib < b_nib) begin
      res = CASC_LT;
    end else if (a_nib > b_nib) begin
      res = CASC_GT;
    end else begin
      res = CASC_EQ;
    end
    return res;
  endfunction

  state_t          r_state;
  state_t          w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic            r_signed;
  logic [IW-1:0]   r_idx;
  logic [2:0]      r_casc;
  logic            r_lt;
  logic            r_eq;
  logic            r_gt;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_finish;
  logic            w_top;
  logic [3:0]      w_raw_a;
  logic [3:0]      w_raw_b;
  logic [3:0]      w_nib_a;
  logic [3:0]      w_nib_b;
  logic [2:0]      w_slice;

  // Select the current nibble. In signed mode the sign bit of the top nibble
  // is flipped, which maps two's-complement ordering onto unsigned ordering.
  always_comb begin
    w_raw_a = r_a[{r_idx, 2'b00} +: 4];
    w_raw_b = r_b[{r_idx, 2'b00} +: 4];
    w_top   = (r_idx == IW'(NIB - 1));
    w_nib_a = {w_raw_a[3] ^ (r_signed & w_top), w_raw_a[2:0]};
    w_nib_b = {w_raw_b[3] ^ (r_signed & w_top), w_raw_b[2:0]};
    w_slice = cmp_slice(w_nib_a, w_nib_b, r_casc);
  end

  // Next-state logic and the accept/finish strobes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if ((w_slice != CASC_EQ) || (r_idx == IW'(0))) begin
          w_finish     = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand capture, nibble walk, and the registered result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_signed    <= 1'b0;
      r_idx       <= '0;
      r_casc      <= 3'b000;
      r_lt        <= 1'b0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= a_in;
        r_b      <= b_in;
        r_signed <= signed_in;
        r_idx    <= IW'(NIB - 1);
        r_casc   <= CASC_EQ;
      end else if (r_state == S_RUN) begin
        r_casc <= w_slice;
        if (w_finish) begin
          r_lt <= w_slice[2];
          r_eq <= w_slice[1];
          r_gt <= w_slice[0];
        end else begin
          r_idx <= r_idx - IW'(1);
        end
      end
      r_out_valid <= (w_next_state == S_DONE);
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign lt        = r_lt;
  assign eq        = r_eq;
  assign gt        = r_gt;

endmodule

// File: tb/tb_nibble_cmp_seq.sv
// Testbench for nibble_cmp_seq. It drives a WIDTH=16 and a WIDTH=4 instance
// and checks both against directed vectors and an arithmetic reference model.
module tb_nibble_cmp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_drv = 16'h0;
  logic [15:0] b_drv = 16'h0;
  logic        s_drv = 1'b0;
  logic        out_ready = 1'b0;
  logic        iv16 = 1'b0;
  logic        iv4 = 1'b0;
  logic        sel = 1'b0;

  logic ir16, ov16, lt16, eq16, gt16, busy16;
  logic ir4, ov4, lt4, eq4, gt4, busy4;
  logic m_in_ready, m_out_valid, m_lt, m_eq, m_gt, m_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_cmp_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a_in(a_drv), .b_in(b_drv), .signed_in(s_drv),
    .out_valid(ov16), .out_ready(out_ready),
    .lt(lt16), .eq(eq16), .gt(gt16), .busy(busy16)
  );

  nibble_cmp_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a_in(a_drv[3:0]), .b_in(b_drv[3:0]), .signed_in(s_drv),
    .out_valid(ov4), .out_ready(out_ready),
    .lt(lt4), .eq(eq4), .gt(gt4), .busy(busy4)
  );

  // View of whichever instance is currently under test.
  always_comb begin
    m_in_ready  = sel ? ir4   : ir16;
    m_out_valid = sel ? ov4   : ov16;
    m_lt        = sel ? lt4   : lt16;
    m_eq        = sel ? eq4   : eq16;
    m_gt        = sel ? gt4   : gt16;
    m_busy      = sel ? busy4 : busy16;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        w4;
    logic [2:0]  exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer compare plus first differing nibble from the top.
  task automatic ref_cmp(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int width, output logic [2:0] res, output int k);
    longint va, vb;
    int nib;
    va = 0;
    vb = 0;
    for (int i = 0; i < width; i++) begin
      va += longint'(a[i]) << i;
      vb += longint'(b[i]) << i;
    end
    if (s && a[width-1]) va -= (longint'(1) << width);
    if (s && b[width-1]) vb -= (longint'(1) << width);
    res = (va < vb) ? 3'b100 : ((va > vb) ? 3'b001 : 3'b010);
    nib = width / 4;
    k = nib;
    for (int i = nib - 1; i >= 0; i--) begin
      if (((a >> (4 * i)) & 16'hF) != ((b >> (4 * i)) & 16'hF)) begin
        k = nib - i;
        break;
      end
    end
  endtask

  // Issue one request to the selected instance; called #1 after a rising edge.
  task automatic do_op(input logic which, input logic [15:0] a, input logic [15:0] b,
                       input logic s, output logic [2:0] res, output int lat);
    sel = which;
    #0;
    check("in_ready_before_accept", {31'd0, m_in_ready}, 32'd1);
    a_drv = a;
    b_drv = b;
    s_drv = s;
    if (which) iv4 = 1'b1; else iv16 = 1'b1;
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    iv4 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!m_out_valid && lat < 40);
    if (!m_out_valid) check("result_timeout", 32'd0, 32'd1);
    res = {m_lt, m_eq, m_gt};
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_in_ready", {31'd0, m_in_ready}, 32'd1);
    check("drain_busy", {31'd0, m_busy}, 32'd0);
    check("drain_out_valid", {31'd0, m_out_valid}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [2:0] res;
    logic [2:0] exp_res;
    int lat;
    int k;
    logic seen;

    vecs.push_back('{16'h1234, 16'h1234, 1'b0, 1'b0, 3'b010, 4});
    vecs.push_back('{16'h9000, 16'h1FFF, 1'b0, 1'b0, 3'b001, 1});
    vecs.push_back('{16'h9000, 16'h1FFF, 1'b1, 1'b0, 3'b100, 1});
    vecs.push_back('{16'h12A4, 16'h12B4, 1'b0, 1'b0, 3'b100, 3});
    vecs.push_back('{16'h12A4, 16'h12B4, 1'b1, 1'b0, 3'b100, 3});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 1'b0, 3'b100, 1});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 3'b100, 1});
    vecs.push_back('{16'h0001, 16'h0000, 1'b0, 1'b0, 3'b001, 4});
    vecs.push_back('{16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 3'b001, 4});
    vecs.push_back('{16'h0007, 16'h0008, 1'b1, 1'b1, 3'b001, 1});
    vecs.push_back('{16'h0007, 16'h0008, 1'b0, 1'b1, 3'b100, 1});
    vecs.push_back('{16'h0005, 16'h0005, 1'b1, 1'b1, 3'b010, 1});

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #0;
      check("rst_in_ready", {31'd0, m_in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
      check("rst_flags", {29'd0, m_lt, m_eq, m_gt}, 32'd0);
      check("rst_busy", {31'd0, m_busy}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    foreach (vecs[i]) begin
      do_op(vecs[i].w4, vecs[i].a, vecs[i].b, vecs[i].s, res, lat);
      check($sformatf("vec%0d_result", i), {29'd0, res}, {29'd0, vecs[i].exp_res});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
    end

    // Backpressure: gt result held while new operands wait.
    sel = 1'b0;
    a_drv = 16'h9000;
    b_drv = 16'h1FFF;
    s_drv = 1'b0;
    iv16 = 1'b1;
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    @(posedge clk);
    #1;
    check("bp_first_valid", {31'd0, m_out_valid}, 32'd1);
    a_drv = 16'h0001;
    b_drv = 16'h0002;
    iv16 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid_held", {31'd0, m_out_valid}, 32'd1);
      check("bp_flags_held", {29'd0, m_lt, m_eq, m_gt}, 32'd1);
      check("bp_in_ready_low", {31'd0, m_in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_in_ready_after_drain", {31'd0, m_in_ready}, 32'd1);
    check("bp_out_valid_after_drain", {31'd0, m_out_valid}, 32'd0);
    check("bp_flags_kept", {29'd0, m_lt, m_eq, m_gt}, 32'd1);
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    check("bp_accepted_busy", {31'd0, m_busy}, 32'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!m_out_valid && lat < 40);
    check("bp_next_result", {29'd0, m_lt, m_eq, m_gt}, 32'd4);
    check("bp_next_latency", lat, 4);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset during the second RUN cycle of an equal-operand compare.
    a_drv = 16'h5555;
    b_drv = 16'h5555;
    iv16 = 1'b1;
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_in_ready", {31'd0, m_in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, m_out_valid}, 32'd0);
    check("midrst_busy", {31'd0, m_busy}, 32'd0);
    check("midrst_flags", {29'd0, m_lt, m_eq, m_gt}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      seen = seen | m_out_valid;
    end
    check("midrst_no_result", {31'd0, seen}, 32'd0);

    // Randomised compares on both widths against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      logic        w4;
      int          mode;
      w4 = (n % 5) == 4;
      ra = 16'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        rb = 16'($urandom);
      end else if (mode == 1) begin
        rb = ra;
      end else begin
        rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
      end
      rs = 1'($urandom_range(0, 1));
      if (w4) begin
        ra = ra & 16'h000F;
        rb = rb & 16'h000F;
      end
      ref_cmp(ra, rb, rs, w4 ? 4 : 16, exp_res, k);
      do_op(w4, ra, rb, rs, res, lat);
      check($sformatf("rand%0d_result a=%h b=%h s=%0d", n, ra, rb, rs), {29'd0, res}, {29'd0, exp_res});
      check($sformatf("rand%0d_latency", n), lat, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_cmp_seq.md
# nibble_cmp_seq

Sequencer that performs wide magnitude comparison of two WIDTH-bit operands by walking a single 4-bit comparator slice across the operands, one nibble per cycle. It starts at the most-significant nibble and carries a three-way lt/eq/gt cascade state forward, the same one-hot cascade convention our comparator slices use. It stops as soon as a nibble differs. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides, and gives datapaths a low-area alternative to a full-width parallel comparator.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥4, otherwise elaboration error
- NIB (derived), WIDTH/4, number of nibbles; nibble index register is max(1, clog2(NIB)) bits
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  operand request valid
- in_ready  out  1  high only in IDLE
- a_in  in  WIDTH  operand A, sampled on accept
- b_in  in  WIDTH  operand B, sampled on accept
- signed_in  in  1  1 = two's-complement compare, sampled on accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- lt  out  1  A < B
- eq  out  1  A == B
- gt  out  1  A > B
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Accept occurs when in_valid && in_ready.
  - On accept, latch a_in, b_in and signed_in; set idx = NIB-1 and cascade state = eq; go to RUN.
- RUN, each cycle:
  - Compare nibble idx of A and B (unsigned 4-bit) with the internal comparator slice.
  - Signed mode: on nibble NIB-1 only, bit 3 of both A and B nibbles is inverted before the compare.
  - Nibbles differ: latch lt or gt and go to DONE.
  - Nibbles equal and idx == 0: latch eq and go to DONE.
  - Otherwise: decrement idx and stay in RUN.
- DONE:
  - out_valid = 1; lt/eq/gt are exactly one-hot and stable.
  - On out_valid && out_ready, go to IDLE.
- in_valid is ignored outside IDLE. No accept happens in the same cycle as a result drain.
- lt/eq/gt keep their last values after the drain, until the next result is latched.
- Reset at any cycle, including mid-RUN or in DONE:
  - state goes to IDLE; out_valid, lt, eq, gt and busy go to 0; idx goes to 0.
  - The in-flight request is dropped and no result is produced.

## Timing
- Reset values, after the rst_n=0 edge: in_ready=1, out_valid=0, lt=eq=gt=0, busy=0.
- Accept at edge E0. k = nibbles examined: index of the first differing nibble from the top, plus 1, or NIB if the operands are equal; 1 ≤ k ≤ NIB.
- Latency:
  - out_valid rises after edge E_k, i.e. it is visible k cycles after the accept cycle.
  - Best case 1 cycle; worst case (equal operands) NIB cycles.
- Drain at edge D: in_ready=1 and busy=0 in the cycle after D. Minimum request spacing is k+2 cycles.
- in_ready is a pure decode of state (no combinational path from in_valid). out_valid is a registered state decode.
- With NIB=1, every compare takes exactly 1 RUN cycle. Signed inversion applies to that single nibble.

## Test plan
- Reset, then A=0x1234, B=0x1234, unsigned.
  - Required: 4 RUN cycles; out_valid first high 4 cycles after accept; eq=1, lt=gt=0.
- A=0x9000, B=0x1FFF.
  - Unsigned: gt=1 with latency 1.
  - Signed: lt=1 with latency 1.
- A=0x12A4, B=0x12B4, unsigned.
  - Required: lt=1 with latency 3; signed mode gives the same result.
- Backpressure: result gt pending, out_ready=0 for 5 cycles, in_valid=1 throughout with new operands.
  - Required: out_valid, gt and in_ready=0 held stable; new operands not accepted.
  - Raise out_ready: in_ready=1 on the next cycle; the next request is accepted and compared correctly.
- Reset mid-operation: rst_n=0 for one edge during the 2nd RUN cycle of an equal-operand compare.
  - Required: the following cycle shows in_ready=1, out_valid=0, busy=0.
  - out_valid never asserts for the dropped request.
- WIDTH=4 build.
  - A=0x7, B=0x8, signed: gt=1.
  - A=0x7, B=0x8, unsigned: lt=1.
  - Both cases: latency 1.
